// File: rtl/fir_feed_pkg.sv
// fir_feed_pkg: shared defaults, state enum and slot helper
// for the FIR tap feeder (optional flush: FEED_FLUSH_EN).
package fir_feed_pkg;

  localparam int FEED_N    = 4;
  localparam int FEED_TAPS = 10;
  localparam int FEED_IDXW = 4;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } feed_state_e;

  // Slot k of a flattened window/snapshot bus.
  function automatic logic [FEED_N-1:0] slot(
    input logic [FEED_N*FEED_TAPS-1:0] bus,
    input int                          k
  );
    return bus[k*FEED_N +: FEED_N];
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: TAPS x N coefficient registers, one write port.
// Ports: clk, rst, i_we/i_idx/i_data write, o_snap = bank incl. same-edge write.
module fir_coef_bank
  import fir_feed_pkg::*;
#(
  parameter int N    = FEED_N,
  parameter int TAPS = FEED_TAPS,
  parameter int IDXW = FEED_IDXW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDXW-1:0]   i_idx,
  input  logic [N-1:0]      i_data,
  output logic [N*TAPS-1:0] o_snap
);

  logic [N*TAPS-1:0] r_bank;
  logic [N*TAPS-1:0] w_bank_nxt;

  // Out-of-range indices match no slot and are dropped.
  always_comb begin
    w_bank_nxt = r_bank;
    for (int k = 0; k < TAPS; k++) begin
      if (i_we && i_idx == IDXW'(k)) begin
        w_bank_nxt[k*N +: N] = i_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank <= '0;
    end else begin
      r_bank <= w_bank_nxt;
    end
  end

  assign o_snap = w_bank_nxt;

endmodule

// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: serial samples -> TAPS-deep window + coef snapshot.
// Ports: in_* handshake, coef_* write, x_taps/h_taps/out_* to MAC,
// fill_level; flush port only with macro FEED_FLUSH_EN.
module fir_tap_feeder
  import fir_feed_pkg::*;
#(
  parameter int N    = FEED_N,
  parameter int TAPS = FEED_TAPS,
  parameter int IDXW = FEED_IDXW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [IDXW-1:0]   coef_idx,
  input  logic [N-1:0]      coef_data,
`ifdef FEED_FLUSH_EN
  input  logic              flush,
`endif
  output logic [N*TAPS-1:0] x_taps,
  output logic [N*TAPS-1:0] h_taps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   fill_level
);

  localparam logic [IDXW-1:0] FULL = IDXW'(TAPS);
  localparam logic [IDXW-1:0] LAST = IDXW'(TAPS - 1);

  feed_state_e       r_state;
  feed_state_e       w_state_nxt;
  logic [N*TAPS-1:0] r_dl;
  logic [N*TAPS-1:0] r_x;
  logic [N*TAPS-1:0] r_h;
  logic              r_vld;
  logic [IDXW-1:0]   r_fill;
  logic [N*TAPS-1:0] w_snap;
  logic [N*TAPS-1:0] w_dl_shift;
  logic [N-1:0]      w_shift_in;
  logic [IDXW-1:0]   w_fill_inc;
  logic              w_free;
  logic              w_acc;
  logic              w_load;
  logic              w_flush_step;
  logic              w_flush_last;

  fir_coef_bank #(
    .N    (N),
    .TAPS (TAPS),
    .IDXW (IDXW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (coef_we),
    .i_idx  (coef_idx),
    .i_data (coef_data),
    .o_snap (w_snap)
  );

  assign w_free   = !r_vld || out_ready;
  assign in_ready = w_free && (r_state != FLUSH);
  assign w_acc    = in_valid && in_ready;

  assign w_fill_inc = (r_fill == FULL) ? FULL
                                       : r_fill + 1'b1;

`ifdef FEED_FLUSH_EN
  logic [IDXW-1:0] r_fcnt;

  // A flush step needs a free output slot, like a normal load.
  assign w_flush_step = (r_state == FLUSH) && w_free;
  assign w_flush_last = w_flush_step &&
                        (r_fcnt == IDXW'(TAPS - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt <= '0;
    end else if (w_flush_last || r_state != FLUSH) begin
      r_fcnt <= '0;
    end else if (w_flush_step) begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
`else
  assign w_flush_step = 1'b0;
  assign w_flush_last = 1'b0;
`endif

  assign w_shift_in = w_flush_step ? '0 : in_data;
  assign w_dl_shift = {r_dl[N*(TAPS-1)-1:0], w_shift_in};
  assign w_load     = (w_acc && w_fill_inc == FULL) ||
                      w_flush_step;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL: begin
        if (w_acc && r_fill == LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef FEED_FLUSH_EN
        if (flush) begin
          w_state_nxt = FLUSH;
        end
`endif
      end
      FLUSH: begin
        if (w_flush_last) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl   <= '0;
      r_fill <= '0;
      r_x    <= '0;
      r_h    <= '0;
      r_vld  <= 1'b0;
    end else begin
      if (w_flush_last) begin
        r_dl <= '0;
      end else if (w_acc || w_flush_step) begin
        r_dl <= w_dl_shift;
      end
      if (w_flush_last) begin
        r_fill <= '0;
      end else if (w_acc) begin
        r_fill <= w_fill_inc;
      end
      // The snapshot sees a coefficient write on this same edge.
      if (w_load) begin
        r_x   <= w_dl_shift;
        r_h   <= w_snap;
        r_vld <= 1'b1;
      end else if (out_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign x_taps     = r_x;
  assign h_taps     = r_h;
  assign out_valid  = r_vld;
  assign fill_level = r_fill;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// tb_fir_tap_feeder: directed stimulus, windows checked via scoreboard.
// Flush section built only with FEED_FLUSH_EN.
module tb_fir_tap_feeder;
  import fir_feed_pkg::*;

  localparam int N  = 4;
  localparam int T  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [N-1:0]  coef_data;
  logic          flush;
  logic [N*T-1:0] x_taps;
  logic [N*T-1:0] h_taps;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] fill_level;

  always #5 clk = ~clk;

  fir_tap_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
`ifdef FEED_FLUSH_EN
    .flush      (flush),
`endif
    .x_taps     (x_taps),
    .h_taps     (h_taps),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level)
  );

  typedef struct packed {
    logic [N*T-1:0] x;
    logic [N*T-1:0] h;
  } win_t;

  win_t        q[$];
  int          passed = 0;
  int          total  = 0;
  logic [N-1:0] m_dl[T];
  logic [N-1:0] m_bank[T];
  int          m_fill;
  int          m_fcnt;
  bit          m_vld;
  feed_state_e m_state;

  task automatic chk(input string nm,
                     input logic [N*T-1:0] act,
                     input logic [N*T-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [N*T-1:0] pack(input logic [N-1:0] a[T]);
    logic [N*T-1:0] p;
    for (int k = 0; k < T; k++) p[k*N +: N] = a[k];
    return p;
  endfunction

  task automatic mreset();
    for (int k = 0; k < T; k++) begin
      m_dl[k]   = '0;
      m_bank[k] = '0;
    end
    m_fill  = 0;
    m_fcnt  = 0;
    m_vld   = 0;
    m_state = FILL;
    q.delete();
  endtask

  task automatic mshift(input logic [N-1:0] d);
    for (int k = T - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
    m_dl[0] = d;
  endtask

  // One clock: drive, check handshake at negedge, update model at posedge.
  task automatic cyc(input bit v, input logic [N-1:0] d,
                     input bit we, input logic [IW-1:0] idx,
                     input logic [N-1:0] cd, input bit ordy,
                     input bit fl);
    bit free, rdy, acc, load, step;
    feed_state_e st0;
    win_t w;
    in_valid  = v;
    in_data   = d;
    coef_we   = we;
    coef_idx  = idx;
    coef_data = cd;
    out_ready = ordy;
    flush     = fl;
    free = !m_vld || ordy;
    rdy  = free && (m_state != FLUSH);
    acc  = v && rdy;
    @(negedge clk);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_vld);
    chk("fill_level", fill_level, m_fill);
    @(posedge clk);
    if (rst) begin
      mreset();
    end else begin
      st0  = m_state;
      load = 0;
      step = (m_state == FLUSH) && free;
      if (we && idx < T) m_bank[idx] = cd;
      if (acc) begin
        mshift(d);
        if (m_fill < T) m_fill++;
        if (m_fill == T) load = 1;
        if (m_state == FILL && m_fill == T) m_state = RUN;
      end
      if (step) begin
        mshift('0);
        load = 1;
      end
      if (load) begin
        w.x = pack(m_dl);
        w.h = pack(m_bank);
        q.push_back(w);
        m_vld = 1;
      end else if (ordy) begin
        m_vld = 0;
      end
      if (step) begin
        m_fcnt++;
        if (m_fcnt == T - 1) begin
          for (int k = 0; k < T; k++) m_dl[k] = '0;
          m_fill  = 0;
          m_fcnt  = 0;
          m_state = FILL;
        end
      end
`ifdef FEED_FLUSH_EN
      if (st0 == RUN && fl) m_state = FLUSH;
`else
      if (st0 == RUN && fl) m_state = RUN;
`endif
    end
    #1;
    in_valid = 0;
    coef_we  = 0;
    flush    = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL sb_window: got x=%0h expected none", x_taps);
      end else begin
        chk("sb_x", x_taps, q[0].x);
        chk("sb_h", h_taps, q[0].h);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    in_valid  = 0;
    in_data   = '0;
    coef_we   = 0;
    coef_idx  = '0;
    coef_data = '0;
    out_ready = 1;
    flush     = 0;
    rst       = 1;
    repeat (2) @(posedge clk);
    mreset();
    #1 rst = 0;
    chk("rst_x", x_taps, '0);
    chk("rst_h", h_taps, '0);
    chk("rst_vld", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_rdy", in_ready, 1);

    for (int k = 0; k < T; k++)
      cyc(0, '0, 1, IW'(k), N'(k + 1), 1, 0);
    for (int v = 1; v <= T; v++)
      cyc(1, N'(v), 0, '0, '0, 1, 0);
    chk("first_x0", slot(x_taps, 0), 10);
    chk("first_x9", slot(x_taps, 9), 1);
    chk("first_fill", fill_level, 10);
    chk("first_vld", out_valid, 1);

    cyc(1, 4'd11, 0, '0, '0, 1, 0);
    chk("ss_x0", slot(x_taps, 0), 11);
    chk("ss_x9", slot(x_taps, 9), 2);
    chk("ss_h3", slot(h_taps, 3), 4);

    cyc(0, '0, 1, 4'd3, 4'hA, 0, 0);
    chk("hold_h3", slot(h_taps, 3), 4);
    repeat (3) cyc(1, 4'd12, 0, '0, '0, 0, 0);
    chk("hold_x0", slot(x_taps, 0), 11);
    cyc(1, 4'd12, 0, '0, '0, 1, 0);
    chk("bp_x0", slot(x_taps, 0), 12);
    chk("bp_h3", slot(h_taps, 3), 4'hA);

    cyc(0, '0, 1, 4'd12, 4'hF, 1, 0);
    cyc(1, 4'd13, 0, '0, '0, 1, 0);
    chk("bank_h", h_taps, 40'hA98765A321);
    cyc(0, '0, 0, '0, '0, 1, 0);

    for (int v = 1; v <= 5; v++)
      cyc(1, N'(v), 0, '0, '0, 1, 0);
    rst = 1;
    cyc(0, '0, 0, '0, '0, 1, 0);
    rst = 0;
    chk("mid_rst_x", x_taps, '0);
    chk("mid_rst_h", h_taps, '0);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_fill", fill_level, 0);

    cyc(1, 4'd1, 1, 4'd0, 4'd5, 1, 1);
    cyc(1, 4'd2, 1, 4'd9, 4'd7, 1, 0);
    for (int v = 3; v <= 9; v++)
      cyc(1, N'(v), 0, '0, '0, 1, 0);
    cyc(1, 4'd10, 1, 4'd5, 4'hC, 1, 0);
    chk("refill_x0", slot(x_taps, 0), 10);
    chk("refill_x9", slot(x_taps, 9), 1);
    chk("refill_h", h_taps, 40'h7000C00005);

`ifdef FEED_FLUSH_EN
    cyc(0, '0, 0, '0, '0, 1, 1);
    for (int i = 0; i < 40 && m_state == FLUSH; i++)
      cyc(0, '0, 0, '0, '0, (i != 2), 0);
    cyc(0, '0, 0, '0, '0, 0, 0);
    chk("flush_last_x", x_taps, 40'hA000000000);
    chk("flush_fill", fill_level, 0);
`endif

    cyc(1, 4'd5, 0, '0, '0, 1, 0);
    cyc(0, '0, 0, '0, '0, 1, 0);
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_tap_feeder.md
Name: fir_tap_feeder

Overview:
- Upstream producer for the team's parallel 10-tap multiply/accumulate FIR datapath.
- Accepts a serial sample stream through a valid/ready handshake and keeps a TAPS-deep delay line.
- Holds a writable coefficient bank.
- Presents coherent parallel sample-window and coefficient buses, with out_valid/out_ready, to the MAC stage.

Parameters:
- N, 4, sample and coefficient width in bits.
- TAPS, 10, delay-line depth, which is also the coefficient count.
- IDXW, 4, coefficient index width; must satisfy 2**IDXW >= TAPS.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N  serial sample.
- in_valid  in  1  sample present.
- in_ready  out  1  feeder can accept the sample this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_idx  in  IDXW  coefficient slot.
- coef_data  in  N  coefficient value.
- x_taps  out  N*TAPS  window; slot k = bits [k*N +: N]; slot 0 is the newest sample.
- h_taps  out  N*TAPS  coefficient snapshot; slot k pairs with x_taps slot k.
- out_valid  out  1  window and snapshot valid.
- out_ready  in  1  MAC stage consumes the window.
- fill_level  out  IDXW  accepted samples since reset or restart, saturating at TAPS.
- flush  in  1  present only with FEED_FLUSH_EN.

Behaviour:
- Reset (synchronous, active-high) clears the following, overriding any same-cycle handshake or coefficient write:
  - delay line, coefficient bank, x_taps, h_taps all 0;
  - out_valid 0, fill_level 0, state FILL.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready (single output slot). in_ready is also 0 in FLUSH.
- On accept, the delay line shifts: slot k <= slot k-1, slot 0 <= in_data, the oldest sample is dropped. fill_level increments, saturating at TAPS.
- Output register load:
  - Loads when an accept makes fill_level == TAPS (post-increment), i.e. the TAPS-th and every later sample.
  - x_taps gets the post-shift window; h_taps gets the current bank, including any write committed that same edge.
  - out_valid = 1 on the next cycle (latency one cycle from accept).
- Hold: while out_valid && !out_ready, x_taps, h_taps and out_valid are stable, and no accept occurs.
- Consume: out_valid && out_ready with no new load clears out_valid. With a simultaneous load, out_valid stays 1 and new data appears (full throughput, one window per cycle).
- States:
  - FILL: fill_level < TAPS; no output load. Moves to RUN on the TAPS-th accept.
  - RUN: every accept produces a window.
  - FLUSH: only with the macro.
- Coefficient write:
  - On coef_we with coef_idx < TAPS, bank[coef_idx] <= coef_data.
  - coef_idx >= TAPS: the write is ignored.
  - Writes are allowed in any state. An already-presented window never changes; new values appear in the next loaded snapshot.
- No arithmetic is performed. Widths pass through unchanged and the MAC stage owns product and sum growth.

Optional Feature:
- Macro: FEED_FLUSH_EN.
- With the macro:
  - A flush pulse sampled in RUN starts FLUSH on the next cycle. If a sample is accepted on the same edge, it is shifted in first.
  - FLUSH shifts a zero into slot 0 on each cycle where the output slot is free. It generates TAPS-1 zero-padded windows under the normal out_ready hold rules; in_ready = 0 throughout.
  - After the last window: delay line cleared, fill_level 0, state FILL.
  - flush in FILL or FLUSH is ignored.
  - Reset during FLUSH returns to the normal reset state.
- Without the macro: no flush port, no FLUSH state, and behaviour is otherwise identical.

Decomposition:
- Package fir_feed_pkg holds: TAPS, N and IDXW defaults; the state enum {FILL, RUN, FLUSH}; a slot-slice helper function.
- One natural sub-module, fir_coef_bank: the TAPS x N register bank with write port and flattened snapshot output.

Test Plan:
- Fill and first window (N=4, TAPS=10):
  - Stimulus: reset, then stream 1..10 with out_ready=1.
  - Response: out_valid stays 0 until one cycle after the 10th accept; then x_taps slot0=10 and slot9=1; fill_level=10.
- Steady state: sample 11 -> next cycle window slot0=11, slot9=2; in_ready stays 1 at full rate.
- Backpressure:
  - Stimulus: out_ready=0 while out_valid=1.
  - Response: in_ready=0 and the window is held for 3 cycles. Raising out_ready consumes it and the next accept yields slot0=12.
- Coefficients:
  - Stimulus: write idx3=0xA during RUN.
  - Response: the current window is unchanged; the next snapshot has h slot3=0xA.
  - Stimulus: write idx12=0xF. Response: no bank change.
- Reset mid-fill: after 5 accepts assert rst one cycle -> all outputs 0, fill_level 0, and 10 new samples are needed before out_valid.
- Flush (FEED_FLUSH_EN):
  - Stimulus: after the 1..10 window, pulse flush.
  - Response: 9 windows; the last has slot9=10 and all other slots 0; then state FILL, fill_level 0, in_ready=1.
